operation_r_bw16_iter: RTL and testbench

- Primitive-recursion (iteration) stage for the BW-bit operation blocks.
- Sits directly upstream of one child operation block and drives its ST/RD/IN0/IN1 handshake; consumes the child's RES.
- Computes acc0 = IN0; acc(k+1) = g(k, acc(k)) for k = 0..IN1-1, where g is the child. Returns acc(IN1).
- Exposes the same ST-edge / RD handshake as the operation blocks, so it composes like one of them.

---
 rtl/operation_r_bw16_iter.sv | 151 +++++++++++++++
 tb/tb_operation_r_bw16_iter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/operation_r_bw16_iter.sv
// Primitive-recursion stage: acc = IN0, then acc = g(k, acc) for k = 0..IN1-1 via a child block.
// Optional child-response watchdog with ERR output is built when OPR_TIMEOUT_EN is defined.
module operation_r_bw16_iter #(
    parameter int BW  = 16,
    parameter int CW  = 16,
    parameter int TMO = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    output logic          RD,
    output logic [BW-1:0] RES,
    input  logic [BW-1:0] IN0,
    input  logic [CW-1:0] IN1,
    output logic          CH_ST,
    output logic [CW-1:0] CH_IN0,
    output logic [BW-1:0] CH_IN1,
    input  logic          CH_RD,
    input  logic [BW-1:0] CH_RES
`ifdef OPR_TIMEOUT_EN
    ,
    output logic          ERR
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        WAITLO = 2'd2,
        WAITHI = 2'd3
    } state_t;

    state_t        state_r;
    logic          st_old_r;
    logic [BW-1:0] acc_r;
    logic [CW-1:0] n_r;
    logic [CW-1:0] k_r;
    logic          st_edge_s;
    logic          tmo_hit_s;

    assign st_edge_s = ST & ~st_old_r;

`ifdef OPR_TIMEOUT_EN
    // Watchdog is at least 8 bits wide regardless of CW so TMO up to 255 always fits.
    localparam int TW = (TMO > 255) ? $clog2(TMO + 1) : 8;
    logic [TW-1:0] wdog_r;

    assign tmo_hit_s = ((state_r == WAITLO) || (state_r == WAITHI)) && (wdog_r == TW'(TMO - 1));

    // Per-iteration cycle counter, restarted on every child launch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_r <= '0;
        end else if ((state_r == WAITLO) || (state_r == WAITHI)) begin
            wdog_r <= wdog_r + TW'(1);
        end else begin
            wdog_r <= '0;
        end
    end

    // Error flag: set on watchdog expiry, cleared by the next accepted start.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR <= 1'b0;
        end else if (tmo_hit_s) begin
            ERR <= 1'b1;
        end else if ((state_r == IDLE) && st_edge_s) begin
            ERR <= 1'b0;
        end else begin
            ERR <= ERR;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Start-edge history is kept even while in reset.
    always_ff @(posedge CLK) begin
        st_old_r <= ST;
    end

    // Iteration FSM with registered handshake outputs toward both sides.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            RD      <= 1'b1;
            RES     <= '0;
            CH_ST   <= 1'b0;
            CH_IN0  <= '0;
            CH_IN1  <= '0;
            acc_r   <= '0;
            n_r     <= '0;
            k_r     <= '0;
        end else if (tmo_hit_s) begin
            // Abandon the child and report the last good accumulator.
            CH_ST   <= 1'b0;
            RES     <= acc_r;
            RD      <= 1'b1;
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (st_edge_s) begin
                        acc_r   <= IN0;
                        n_r     <= IN1;
                        k_r     <= '0;
                        RD      <= 1'b0;
                        state_r <= CHECK;
                    end else begin
                        RD <= 1'b1;
                    end
                end
                CHECK: begin
                    if (k_r == n_r) begin
                        RES     <= acc_r;
                        RD      <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        CH_IN0  <= k_r;
                        CH_IN1  <= acc_r;
                        CH_ST   <= 1'b1;
                        state_r <= WAITLO;
                    end
                end
                WAITLO: begin
                    if (!CH_RD) begin
                        CH_ST   <= 1'b0;
                        state_r <= WAITHI;
                    end else begin
                        CH_ST <= 1'b1;
                    end
                end
                WAITHI: begin
                    if (CH_RD) begin
                        acc_r   <= CH_RES;
                        k_r     <= k_r + CW'(1);
                        state_r <= CHECK;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    RD      <= 1'b1;
                    CH_ST   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operation_r_bw16_iter.sv
// Self-checking bench for operation_r_bw16_iter with a behavioural child and iteration reference model.
module tb_operation_r_bw16_iter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ST = 1'b0;
    logic        RD;
    logic [15:0] RES;
    logic [15:0] IN0 = 16'h0000;
    logic [15:0] IN1 = 16'h0000;
    logic        CH_ST;
    logic [15:0] CH_IN0;
    logic [15:0] CH_IN1;
    logic        ch_rd;
    logic [15:0] ch_res;
`ifdef OPR_TIMEOUT_EN
    logic        ERR;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    // child behaviour: 0 projection onto CH_IN1, 1 adder, 2 stuck ready
    int          ch_mode = 1;
    int          ch_lat = 2;
    logic        ch_old;
    int          ch_cnt;
    int          trig_cnt;
    logic [15:0] idx_log [64];

    operation_r_bw16_iter #(.BW(16), .CW(16), .TMO(20)) dut (
        .CLK(CLK), .RST(RST), .ST(ST), .RD(RD), .RES(RES), .IN0(IN0), .IN1(IN1),
        .CH_ST(CH_ST), .CH_IN0(CH_IN0), .CH_IN1(CH_IN1), .CH_RD(ch_rd), .CH_RES(ch_res)
`ifdef OPR_TIMEOUT_EN
        , .ERR(ERR)
`endif
    );

    always #5 CLK = ~CLK;

    // Child block model with ST-edge / RD handshake and configurable busy time.
    always @(posedge CLK) begin
        if (RST) begin
            ch_rd    <= 1'b1;
            ch_old   <= 1'b0;
            ch_cnt   <= 0;
            ch_res   <= 16'h0000;
            trig_cnt <= 0;
        end else begin
            ch_old <= CH_ST;
            if (ch_mode == 2) begin
                ch_rd <= 1'b1;
            end else if (CH_ST && !ch_old && ch_rd) begin
                idx_log[trig_cnt % 64] <= CH_IN0;
                trig_cnt <= trig_cnt + 1;
                ch_res   <= (ch_mode == 0) ? CH_IN1 : CH_IN0 + CH_IN1;
                ch_rd    <= 1'b0;
                ch_cnt   <= ch_lat;
            end else if (!ch_rd) begin
                if (ch_cnt <= 1) ch_rd <= 1'b1;
                else ch_cnt <= ch_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: fold the child function over k = 0..n-1.
    function automatic logic [15:0] ref_iter(input int mode, input logic [15:0] a, input int n);
        int acc = a;
        for (int k = 0; k < n; k++) begin
            if (mode == 1) acc = (acc + k) % 65536;
        end
        return acc[15:0];
    endfunction

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge CLK);
        IN0 = a;
        IN1 = b;
        ST  = 1'b1;
        @(negedge CLK);
        ST  = 1'b0;
    endtask

    // Run one operation; optionally inject a spurious start and operand changes mid-run.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit disturb,
                          output logic [15:0] res_got, output int low_cnt);
        launch(a, b);
        low_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (RD) break;
            low_cnt++;
            if (disturb && low_cnt == 6) begin
                ST  = 1'b1;
                IN0 = ~a;
                IN1 = b + 16'd3;
            end
            if (disturb && low_cnt == 7) ST = 1'b0;
            @(negedge CLK);
        end
        if (!RD) check("done_bound", {31'd0, RD}, 32'd1);
        res_got = RES;
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] a;
        logic [15:0] b;
        int          lows;
        int          base;
        int          bound;

        repeat (3) @(negedge CLK);
        check("rst_rd", {31'd0, RD}, 32'd1);
        check("rst_res", {16'd0, RES}, 32'd0);
        check("rst_chst", {31'd0, CH_ST}, 32'd0);
        check("rst_chin0", {16'd0, CH_IN0}, 32'd0);
        check("rst_chin1", {16'd0, CH_IN1}, 32'd0);
`ifdef OPR_TIMEOUT_EN
        check("rst_err", {31'd0, ERR}, 32'd0);
`endif
        RST = 1'b0;
        @(negedge CLK);

        // N = 0: one launch edge, one CHECK edge, no child activity
        base = trig_cnt;
        run_op(16'h0005, 16'd0, 1'b0, r, lows);
        check("n0_res", {16'd0, r}, 32'h5);
        check("n0_rd_low_cycles", lows, 32'd1);
        check("n0_no_chst", trig_cnt - base, 32'd0);

        // projection child: result is IN0, index sequence 0,1,2
        ch_mode = 0; ch_lat = 2;
        base = trig_cnt;
        run_op(16'h1234, 16'd3, 1'b0, r, lows);
        check("proj_res", {16'd0, r}, 32'h1234);
        check("proj_pulses", trig_cnt - base, 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("proj_idx%0d", i), {16'd0, idx_log[(base + i) % 64]}, i);

        ch_mode = 1;
        run_op(16'h0000, 16'd5, 1'b0, r, lows);
        check("add_res", {16'd0, r}, 32'h000A);
        run_op(16'hFFFF, 16'd2, 1'b0, r, lows);
        check("add_wrap", {16'd0, r}, 32'h0000);

        // spurious ST edge and operand changes mid-run must not disturb
        base = trig_cnt;
        run_op(16'h0100, 16'd4, 1'b1, r, lows);
        check("disturb_res", {16'd0, r}, {16'd0, ref_iter(1, 16'h0100, 4)});
        check("disturb_pulses", trig_cnt - base, 32'd4);

        // random operands, child latency and child function
        for (int t = 0; t < 16; t++) begin
            ch_mode = $urandom_range(0, 1);
            ch_lat  = $urandom_range(1, 4);
            a = 16'($urandom);
            b = 16'($urandom_range(0, 7));
            base = trig_cnt;
            run_op(a, b, 1'b0, r, lows);
            check($sformatf("rand%0d_res", t), {16'd0, r}, {16'd0, ref_iter(ch_mode, a, int'(b))});
            check($sformatf("rand%0d_pulses", t), trig_cnt - base, {16'd0, b});
        end

        // reset while waiting for the child to return
        ch_mode = 1; ch_lat = 4;
        launch(16'h0100, 16'd4);
        bound = 0;
        while (!(CH_ST == 1'b0 && ch_rd == 1'b0) && bound < 200) begin
            @(negedge CLK);
            bound++;
        end
        check("waithi_reached", {31'd0, (bound < 200)}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_rd", {31'd0, RD}, 32'd1);
        check("midrst_chst", {31'd0, CH_ST}, 32'd0);
        check("midrst_res", {16'd0, RES}, 32'd0);
        repeat (3) @(negedge CLK);
        run_op(16'h0007, 16'd3, 1'b0, r, lows);
        check("after_rst_res", {16'd0, r}, {16'd0, ref_iter(1, 16'h0007, 3)});

        // child that never acknowledges
        ch_mode = 2;
        launch(16'h0ABC, 16'd3);
        bound = 0;
        while (!CH_ST && bound < 50) begin
            @(negedge CLK);
            bound++;
        end
        check("stuck_chst_seen", {31'd0, CH_ST}, 32'd1);
`ifdef OPR_TIMEOUT_EN
        lows = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (RD) begin
                lows = i;
                break;
            end
        end
        check("tmo_cycles", lows, 32'd20);
        check("tmo_err", {31'd0, ERR}, 32'd1);
        check("tmo_res", {16'd0, RES}, 32'h0ABC);
        check("tmo_chst", {31'd0, CH_ST}, 32'd0);
        ch_mode = 1; ch_lat = 2;
        run_op(16'h0003, 16'd2, 1'b0, r, lows);
        check("tmo_err_clr", {31'd0, ERR}, 32'd0);
        check("tmo_next_res", {16'd0, r}, {16'd0, ref_iter(1, 16'h0003, 2)});
`else
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (RD) lows++;
        end
        check("stuck_rd_high_cycles", lows, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        ch_mode = 1; ch_lat = 2;
        repeat (2) @(negedge CLK);
        run_op(16'h0003, 16'd2, 1'b0, r, lows);
        check("stuck_next_res", {16'd0, r}, {16'd0, ref_iter(1, 16'h0003, 2)});
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
